// File: rtl/mem_arbiter.sv
// Shares one 128-bit block memory port between i-cache refills and d-cache refills/write-backs.
// Latency: request to release is memory latency + 3 cycles (IDLE decision, ISSUE, RESP).
// Backpressure: losing or waiting requester is held on busywait; optional MEM_ARB_DPRIO_EN gives the d-cache fixed priority.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int BLK_W  = 128
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_i_read,
   input  logic [ADDR_W-1:0] i_i_address,
   output logic [BLK_W-1:0]  o_i_readdata,
   output logic              o_i_busywait,
   input  logic              i_d_read,
   input  logic              i_d_write,
   input  logic [ADDR_W-1:0] i_d_address,
   input  logic [BLK_W-1:0]  i_d_writedata,
   output logic [BLK_W-1:0]  o_d_readdata,
   output logic              o_d_busywait,
   output logic              o_m_read,
   output logic              o_m_write,
   output logic [ADDR_W-1:0] o_m_address,
   output logic [BLK_W-1:0]  o_m_writedata,
   input  logic [BLK_W-1:0]  i_m_readdata,
   input  logic              i_m_busywait
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   logic                r_owner_d;
   logic                r_last_d;
   logic [BLK_W-1:0]    r_buf;
   logic                r_m_read;
   logic                r_m_write;
   logic [ADDR_W-1:0]   r_m_address;
   logic [BLK_W-1:0]    r_m_writedata;

   logic w_i_req;
   logic w_d_req;
   logic w_grant_d;
   logic w_resp_i;
   logic w_resp_d;

   assign w_i_req = i_i_read;
   assign w_d_req = i_d_read | i_d_write;

`ifdef MEM_ARB_DPRIO_EN
   assign w_grant_d = w_d_req;
`else
   // On a tie the port that did not win last time gets the grant.
   assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_owner_d     <= 1'b0;
         r_last_d      <= 1'b1;
         r_buf         <= '0;
         r_m_read      <= 1'b0;
         r_m_write     <= 1'b0;
         r_m_address   <= '0;
         r_m_writedata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_i_req || w_d_req) begin
                  r_owner_d <= w_grant_d;
                  r_last_d  <= w_grant_d;
                  r_state   <= S_ISSUE;
                  if (w_grant_d) begin
                     // Read and write together is a write-back; no read is issued.
                     r_m_read      <= i_d_read & ~i_d_write;
                     r_m_write     <= i_d_write;
                     r_m_address   <= i_d_address;
                     r_m_writedata <= i_d_writedata;
                  end else begin
                     r_m_read    <= 1'b1;
                     r_m_write   <= 1'b0;
                     r_m_address <= i_i_address;
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               if (!i_m_busywait) begin
                  if (r_m_read) begin
                     r_buf <= i_m_readdata;
                  end
                  r_m_read  <= 1'b0;
                  r_m_write <= 1'b0;
                  r_state   <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_resp_i = (r_state == S_RESP) & ~r_owner_d;
   assign w_resp_d = (r_state == S_RESP) &  r_owner_d;

   assign o_i_busywait  = w_i_req & ~w_resp_i;
   assign o_d_busywait  = w_d_req & ~w_resp_d;
   assign o_i_readdata  = r_buf;
   assign o_d_readdata  = r_buf;
   assign o_m_read      = r_m_read;
   assign o_m_write     = r_m_write;
   assign o_m_address   = r_m_address;
   assign o_m_writedata = r_m_writedata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int BW = 128;
`ifdef MEM_ARB_DPRIO_EN
   localparam bit DPRIO = 1'b1;
`else
   localparam bit DPRIO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_read, d_read, d_write;
   logic [AW-1:0] i_addr, d_addr;
   logic [BW-1:0] d_wdata;
   logic [BW-1:0] i_rdata, d_rdata;
   logic          i_bw, d_bw;
   logic          m_read, m_write;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_wdata, m_rdata;
   logic          m_busywait;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .BLK_W(BW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_i_read(i_read), .i_i_address(i_addr), .o_i_readdata(i_rdata), .o_i_busywait(i_bw),
      .i_d_read(d_read), .i_d_write(d_write), .i_d_address(d_addr), .i_d_writedata(d_wdata),
      .o_d_readdata(d_rdata), .o_d_busywait(d_bw),
      .o_m_read(m_read), .o_m_write(m_write), .o_m_address(m_addr), .o_m_writedata(m_wdata),
      .i_m_readdata(m_rdata), .i_m_busywait(m_busywait)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // op: 0 = I read, 1 = D read, 2 = D write, 3 = D read+write
   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } req_t;

   logic [BW-1:0] mem [logic [AW-1:0]];

   function automatic logic [BW-1:0] rdmem(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {4{{4'h0, a}}};
   endfunction

   req_t q_i[$];
   req_t q_d[$];
   req_t cur_i, cur_d, win_req;
   bit   act_i, act_d;
   int   log_q[$];

   int   cyc = 0;
   bit   m_active, pend, lg_d, prev_strobe, rel_reset;
   int   issue_cyc, rel_at, free_at, strobe_cnt, last_strobe, last_rel_cyc;
   int   mcnt, lat, fixed_lat;
   logic [BW-1:0] exp_rd, last_rdata;

   task automatic model_reset();
      m_active    = 1'b0;
      pend        = 1'b0;
      rel_at      = -1;
      free_at     = 0;
      lg_d        = 1'b1;
      prev_strobe = 1'b0;
   endtask

   function automatic bit all_idle();
      return !act_i && !act_d && q_i.size() == 0 && q_d.size() == 0 && !m_active && !pend;
   endfunction

   task automatic step();
      bit strobe, rel_i, rel_d, wd;
      @(negedge clk);
      if (rel_reset) begin
         rst_n     = 1'b1;
         rel_reset = 1'b0;
      end
      cyc++;
      // memory responder: busy for lat cycles after the strobe appears
      strobe = m_read | m_write;
      if (strobe) begin
         if (!prev_strobe) begin
            mcnt       = 0;
            lat        = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            m_busywait = 1'($urandom_range(0, 1));
         end else begin
            mcnt++;
            m_busywait = (mcnt < lat);
         end
      end else begin
         m_busywait = 1'($urandom_range(0, 1));
      end
      prev_strobe = strobe;
      m_rdata = rdmem(m_addr);
      #1;
      if (pend) begin
         pend       = 1'b0;
         m_active   = 1'b1;
         issue_cyc  = cyc;
         strobe_cnt = 0;
         log_q.push_back(int'(win_req.op));
      end
      if (m_active) begin
         chk("m_read", m_read, win_req.op == 2'd0 || win_req.op == 2'd1);
         chk("m_write", m_write, win_req.op >= 2'd2);
         chk("m_addr", m_addr, win_req.addr);
         if (win_req.op >= 2'd2) chk("m_wdata", m_wdata, win_req.data);
         strobe_cnt++;
         if (cyc > issue_cyc && !m_busywait) begin
            m_active    = 1'b0;
            rel_at      = cyc + 1;
            free_at     = cyc + 2;
            last_strobe = strobe_cnt;
            exp_rd      = rdmem(win_req.addr);
            if (win_req.op >= 2'd2) mem[win_req.addr] = win_req.data;
         end
      end else begin
         chk("m_idle", {m_read, m_write}, 2'b00);
      end
      rel_i = (cyc == rel_at) && (win_req.op == 2'd0);
      rel_d = (cyc == rel_at) && (win_req.op != 2'd0);
      chk("i_busywait", i_bw, act_i && !rel_i);
      chk("d_busywait", d_bw, act_d && !rel_d);
      if (rel_i) chk("i_rdata", i_rdata, exp_rd);
      if (rel_d && win_req.op == 2'd1) chk("d_rdata", d_rdata, exp_rd);
      if (rel_i || rel_d) begin
         last_rel_cyc = cyc;
         last_rdata   = rel_i ? i_rdata : d_rdata;
      end
      // requesters drop at the end of their release cycle, then take the next queued op
      if (rel_i) act_i = 1'b0;
      if (rel_d) act_d = 1'b0;
      if (!act_i && q_i.size() != 0) begin cur_i = q_i.pop_front(); act_i = 1'b1; end
      if (!act_d && q_d.size() != 0) begin cur_d = q_d.pop_front(); act_d = 1'b1; end
      i_read  = act_i;
      i_addr  = cur_i.addr;
      d_read  = act_d && (cur_d.op == 2'd1 || cur_d.op == 2'd3);
      d_write = act_d && (cur_d.op >= 2'd2);
      d_addr  = cur_d.addr;
      d_wdata = cur_d.data;
      if (!m_active && !pend && cyc >= free_at && (act_i || act_d)) begin
         wd      = DPRIO ? act_d : (act_d && (!act_i || !lg_d));
         pend    = 1'b1;
         lg_d    = wd;
         win_req = wd ? cur_d : cur_i;
      end
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      do begin
         step();
         n++;
      end while (!all_idle() && n < max);
      chk("drain", all_idle(), 1'b1);
   endtask

   function automatic req_t mk(input logic [1:0] op, input logic [AW-1:0] a, input logic [BW-1:0] d);
      req_t r;
      r.op = op; r.addr = a; r.data = d;
      return r;
   endfunction

   int c0;

   initial begin
      rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      m_rdata = '0; m_busywait = 1'b1;
      act_i = 0; act_d = 0; fixed_lat = 0; rel_reset = 0;
      cur_i = '0; cur_d = '0; win_req = '0; last_rdata = '0; exp_rd = '0;
      model_reset();
      repeat (2) @(negedge clk);
      i_read = 1'b1;
      #1;
      chk("rst_m_read", m_read, 1'b0);
      chk("rst_m_write", m_write, 1'b0);
      chk("rst_m_addr", m_addr, '0);
      chk("rst_m_wdata", m_wdata, '0);
      chk("rst_rdata", i_rdata, '0);
      chk("rst_i_bw_held", i_bw, 1'b1);
      chk("rst_d_bw", d_bw, 1'b0);
      i_read = 1'b0;
      rel_reset = 1'b1;
      step();

      // single I refill, memory latency 5
      mem[28'h0000010] = {16{8'hA5}};
      fixed_lat = 5;
      log_q.delete();
      q_i.push_back(mk(2'd0, 28'h0000010, '0));
      step();
      c0 = cyc;
      run_idle(50);
      chk("t_i_latency", last_rel_cyc - c0, 7);
      chk("t_i_strobe_cycles", last_strobe, 6);
      chk("t_i_rdata", last_rdata, {16{8'hA5}});
      fixed_lat = 0;

      // single D write-back
      log_q.delete();
      q_d.push_back(mk(2'd2, 28'h0000020, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_CDEF));
      run_idle(50);
      chk("t_dw_op", log_q[0], 2);

      // simultaneous refills: last grant was D, so I first
      log_q.delete();
      q_i.push_back(mk(2'd0, 28'h0000030, '0));
      q_d.push_back(mk(2'd1, 28'h0000031, '0));
      run_idle(60);
      chk("t_tie1_first", log_q[0], DPRIO ? 1 : 0);
      chk("t_tie1_second", log_q[1], DPRIO ? 0 : 1);
      log_q.delete();
      q_i.push_back(mk(2'd0, 28'h0000032, '0));
      run_idle(50);
      log_q.delete();
      q_i.push_back(mk(2'd0, 28'h0000033, '0));
      q_d.push_back(mk(2'd1, 28'h0000034, '0));
      run_idle(60);
      chk("t_tie2_first", log_q[0], 1);
      chk("t_tie2_second", log_q[1], 0);

      // write-back then refill of the same block with an I refill pending
      log_q.delete();
      q_d.push_back(mk(2'd2, 28'h0000040, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555));
      q_d.push_back(mk(2'd1, 28'h0000040, '0));
      q_i.push_back(mk(2'd0, 28'h0000041, '0));
      run_idle(80);
      chk("t_wb_0", log_q[0], 2);
      chk("t_wb_1", log_q[1], DPRIO ? 1 : 0);
      chk("t_wb_2", log_q[2], DPRIO ? 0 : 1);

      // read and write together behave as a write
      log_q.delete();
      q_d.push_back(mk(2'd3, 28'h0000050, 128'h0BAD_F00D_CAFE_BABE_0123_4567_89AB_CDEF));
      q_d.push_back(mk(2'd1, 28'h0000050, '0));
      run_idle(60);
      chk("t_both_op", log_q[0], 3);

      // reset while waiting on memory; held request restarts afterwards
      fixed_lat = 6;
      q_i.push_back(mk(2'd0, 28'h0000060, '0));
      c0 = 0;
      do begin step(); c0++; end while (!(m_active && cyc >= issue_cyc + 2) && c0 < 20);
      chk("t_rst_reached_wait", m_active, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t_rst_m_read", m_read, 1'b0);
      chk("t_rst_m_write", m_write, 1'b0);
      chk("t_rst_i_bw", i_bw, 1'b1);
      model_reset();
      log_q.delete();
      rel_reset = 1'b1;
      run_idle(50);
      chk("t_rst_retry_cnt", log_q.size(), 1);
      chk("t_rst_retry_op", log_q[0], 0);
      fixed_lat = 0;

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (q_i.size() == 0 && !act_i && $urandom_range(0, 3) == 0)
            q_i.push_back(mk(2'd0, AW'($urandom_range(0, 7) + 'h100), '0));
         if (q_d.size() == 0 && !act_d && $urandom_range(0, 3) == 0)
            q_d.push_back(mk(2'($urandom_range(1, 3)), AW'($urandom_range(0, 7) + 'h100),
                             {$urandom, $urandom, $urandom, $urandom}));
         step();
      end
      run_idle(100);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
